mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYC, default 5, setting the busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYC, default 10, setting the busy cycles for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, EX-stage HI/LO operation valid this cycle.
REQ-006 The block SHALL have port op, input, 3, operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 The block SHALL have port rs, input, 32, first operand / MTHI/MTLO data.
REQ-008 The block SHALL have port rt, input, 32, second operand.
REQ-009 The block SHALL have port cancel, input, 1, EX instruction flushed by exception or interrupt this cycle.
REQ-010 The block SHALL have port md_use, input, 1, D-stage instruction is MFHI/MFLO/MULT/MULTU/DIV/DIVU/MTHI/MTLO.
REQ-011 The block SHALL have port busy, output, 1, multi-cycle operation in progress.
REQ-012 The block SHALL have port stall, output, 1, freeze F/D and bubble E.
REQ-013 The block SHALL have port hi, output, 32, architectural HI register.
REQ-014 The block SHALL have port lo, output, 32, architectural LO register.

Function
REQ-015 The block SHALL implement two states, IDLE and BUSY, plus a down-counter cnt sized for max(MULT_CYC, DIV_CYC).
REQ-016 In IDLE, start=1, cancel=0, op in 0-3 SHALL latch rs, rt and op, load cnt with MULT_CYC or DIV_CYC, and enter BUSY at that edge.
REQ-017 In BUSY, cnt SHALL decrement each edge; the edge at which cnt reaches 0 SHALL write hi/lo and return to IDLE.
REQ-018 busy SHALL be 1 for exactly MULT_CYC (or DIV_CYC) cycles following the start edge; hi/lo SHALL be updated at the edge ending the last busy cycle.
REQ-019 MULT/MULTU SHALL write {hi,lo} = signed/unsigned 64-bit product of latched operands.
REQ-020 DIV SHALL write lo = signed quotient truncated toward zero and hi = remainder with the dividend's sign.
REQ-021 DIVU SHALL write the unsigned quotient to lo and the unsigned remainder to hi.
REQ-022 For DIV, 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-023 Divide with latched rt=0 SHALL still run DIV_CYC busy cycles and SHALL leave hi and lo unchanged.
REQ-024 In IDLE, start=1, cancel=0, op=4 (MTHI) or op=5 (MTLO) SHALL write rs to hi or lo respectively at the next edge, with no busy assertion.
REQ-025 start with cancel=1 SHALL have no effect on state, hi or lo.
REQ-026 cancel during BUSY SHALL NOT abort; the started operation completes.
REQ-027 start while BUSY SHALL be ignored.
REQ-028 op 6-7 SHALL be ignored.
REQ-029 stall SHALL be combinational: md_use & (busy | (start & ~cancel & op<=3)).
REQ-030 hi/lo SHALL be readable combinationally at all times; during BUSY they SHALL hold pre-operation values.

Reset
REQ-031 Asserting reset SHALL immediately, independent of clk, force state=IDLE, cnt=0, busy=0, hi=0, lo=0, and clear latched operands.
REQ-032 Reset asserted during BUSY SHALL discard the operation with no hi/lo write.
REQ-033 During reset, stall SHALL equal md_use & start & ~cancel & (op<=3).
REQ-034 After reset deasserts, the first rising edge SHALL accept start normally.

Verification
REQ-035 MULT rs=0xFFFFFFFE, rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-037 DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIVU rt=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> 10 busy cycles, hi=0x11, lo=0x22 retained.
REQ-039 DIV started, md_use=1 each cycle, cancel pulsed on cycle 3, new start issued on cycle 4 -> stall high all 10 cycles, original result written, second start ignored.
REQ-040 Reset pulsed mid-clock on busy cycle 2 of MULT -> busy=0, hi=lo=0 immediately; following MTLO rs=0x5 -> lo=0x5 next edge.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle HI/LO multiply/divide controller with pipeline stall generation.
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        cancel,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rs, r_rt, r_hi, r_lo;
  logic [1:0]    r_op;
  logic          w_sa, w_sb;
  logic [63:0]   w_prod;
  logic [31:0]   w_a, w_b, w_uq, w_ur, w_q, w_r;
  // Sign-extending both operands makes the low 64 bits of one unsigned multiply serve MULT and MULTU.
  always_comb begin
    w_sa   = ~r_op[0] & r_rs[31];
    w_sb   = ~r_op[0] & r_rt[31];
    w_prod = {{32{w_sa}}, r_rs} * {{32{w_sb}}, r_rt};
    w_a    = w_sa ? -r_rs : r_rs;
    w_b    = w_sb ? -r_rt : r_rt;
    w_uq   = w_a / w_b;
    w_ur   = w_a % w_b;
    w_q    = (w_sa ^ w_sb) ? -w_uq : w_uq;
    w_r    = w_sa ? -w_ur : w_ur;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (r_state == IDLE) begin
      if (start & ~cancel) begin
        if (~op[2]) begin
          r_rs    <= rs;
          r_rt    <= rt;
          r_op    <= op[1:0];
          r_cnt   <= op[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
          r_state <= BUSY;
        end else begin
          if (op == 3'd4) r_hi <= rs;
          if (op == 3'd5) r_lo <= rs;
        end
      end
    end else begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        r_state <= IDLE;
        if (~r_op[1]) {r_hi, r_lo} <= w_prod;
        else if (r_rt != 32'd0) begin
          r_hi <= w_r;
          r_lo <= w_q;
        end
      end
    end
  end
  assign busy  = (r_state == BUSY);
  assign stall = md_use & (busy | (start & ~cancel & ~op[2]));
  assign hi    = r_hi;
  assign lo    = r_lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against a cycle-level arithmetic model.
module tb_mdu_ctrl;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, cancel = 1'b0, md_use = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs = '0, rt = '0;
  logic        busy, stall;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 0;
  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .md_use(md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // Result an operation would produce, from the arithmetic definition of each op.
  task automatic compute(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sp, sa, sb;
    logic [63:0] up;
    p_wr = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 3'd0) begin
      sp = sa * sb;
      {p_hi, p_lo} = sp;
    end else if (o == 3'd1) begin
      up = {32'd0, a} * {32'd0, b};
      {p_hi, p_lo} = up;
    end else if (b == 32'd0) p_wr = 0;
    else if (o == 3'd2) begin
      sp = sa / sb;
      p_lo = sp[31:0];
      sp = sa % sb;
      p_hi = sp[31:0];
    end else begin
      p_lo = a / b;
      p_hi = a % b;
    end
  endtask
  task automatic step(input logic st, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic mu);
    start = st; op = o; rs = a; rt = b; cancel = c; md_use = mu;
    #1;
    check("stall", stall, mu & ((m_left > 0) | (st & ~c & (o <= 3'd3))));
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (st && !c) begin
      if (o <= 3'd3) begin
        compute(o, a, b);
        m_left = o[1] ? 10 : 5;
      end else if (o == 3'd4) m_hi = a;
      else if (o == 3'd5) m_lo = a;
    end
    #1;
    check("busy", busy, m_left > 0);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask
  task automatic idle(input int n, input logic mu);
    for (int i = 0; i < n; i++) step(0, 3'd0, 32'd0, 32'd0, 0, mu);
  endtask
  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = $urandom_range(1, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction
  initial begin
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    start = 1; md_use = 1; op = 3'd2; #1;
    check("rst_stall_div", stall, 1'b1);
    op = 3'd4; #1;
    check("rst_stall_mthi", stall, 1'b0);
    op = 3'd2; cancel = 1; #1;
    check("rst_stall_cancel", stall, 1'b0);
    cancel = 0; start = 0; md_use = 0;
    @(negedge clk); reset = 0;
    step(1, 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0);
    idle(5, 0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    step(1, 3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
    idle(5, 0);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    step(1, 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    idle(10, 0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    step(1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    idle(10, 0);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);
    step(1, 3'd4, 32'h11, 32'd0, 0, 0);
    step(1, 3'd5, 32'h22, 32'd0, 0, 0);
    step(1, 3'd3, 32'h1234, 32'd0, 0, 0);
    idle(10, 0);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);
    step(1, 3'd6, 32'h77, 32'd0, 0, 0);
    step(1, 3'd4, 32'h99, 32'd0, 1, 1);
    check("cancel_hi", hi, 32'h11);
    // Cancel on busy cycle 3 and a fresh start on cycle 4 must neither abort nor restart.
    step(1, 3'd2, 32'd100, 32'd7, 0, 1);
    for (int i = 1; i <= 10; i++) step(i == 4, 3'd0, 32'd3, 32'd3, i == 3, 1);
    check("cancel_div_lo", lo, 32'd14);
    check("cancel_div_hi", hi, 32'd2);
    step(0, 3'd0, 32'd0, 32'd0, 0, 0);
    check("after_busy", busy, 1'b0);
    step(1, 3'd0, 32'd6, 32'd7, 0, 0);
    step(0, 3'd0, 32'd0, 32'd0, 0, 0);
    #3 reset = 1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    m_left = 0; m_hi = 0; m_lo = 0;
    reset = 0;
    step(1, 3'd5, 32'h5, 32'd0, 0, 0);
    check("post_rst_mtlo", lo, 32'h5);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1), 3'($urandom_range(0, 7)), pick(), pick(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 1));
    idle(11, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
